// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel synchroniser, mode-qualified edge pulses,
// holdoff against chatter, sticky flag and saturating count of reported edges.

module edge_detector_ch #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             level_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic             p_edge_o,
   output logic             n_edge_o,
   output logic             evt_flag_o,
   output logic [CNT_W-1:0] edge_cnt_o
);

   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HW-1:0]    HOLD_LD = HW'(HOLDOFF);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = level_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q, sync_d;

         always_comb begin
            sync_d[0] = level_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
         end

         always_ff @(posedge clk) begin
            if (!reset_n) sync_q <= '0;
            else          sync_q <= sync_d;
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   logic             prev_q, prev_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             p_edge_q, p_edge_d;
   logic             n_edge_q, n_edge_d;
   logic             evt_flag_q, evt_flag_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             hold_zero, rep_rise, rep_fall, rep;

   always_comb begin
      hold_zero = (hold_q == '0);
      rep_rise  = s & ~prev_q & mode_i[0] & hold_zero;
      rep_fall  = ~s & prev_q & mode_i[1] & hold_zero;
      rep       = rep_rise | rep_fall;

      // prev follows the input unconditionally so a suppressed edge is lost, not deferred
      prev_d     = s;
      hold_d     = rep ? HOLD_LD : (hold_zero ? '0 : hold_q - HW'(1));
      p_edge_d   = rep_rise;
      n_edge_d   = rep_fall;
      evt_flag_d = rep | (evt_flag_q & ~clr_i);

      edge_cnt_d = edge_cnt_q;
      if (clr_i)                           edge_cnt_d = {{(CNT_W-1){1'b0}}, rep};
      else if (rep && edge_cnt_q != CNT_MAX) edge_cnt_d = edge_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q     <= 1'b0;
         hold_q     <= '0;
         p_edge_q   <= 1'b0;
         n_edge_q   <= 1'b0;
         evt_flag_q <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         prev_q     <= prev_d;
         hold_q     <= hold_d;
         p_edge_q   <= p_edge_d;
         n_edge_q   <= n_edge_d;
         evt_flag_q <= evt_flag_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign p_edge_o   = p_edge_q;
   assign n_edge_o   = n_edge_q;
   assign evt_flag_o = evt_flag_q;
   assign edge_cnt_o = edge_cnt_q;

endmodule

module edge_detector_multi #(
   parameter int CH          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 4,
   parameter int CNT_W       = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CH-1:0]       level,
   input  logic [2*CH-1:0]     mode,
   input  logic [CH-1:0]       clr,
   output logic [CH-1:0]       p_edge,
   output logic [CH-1:0]       n_edge,
   output logic [CH-1:0]       any_edge,
   output logic [CH-1:0]       evt_flag,
   output logic                irq,
   output logic [CH*CNT_W-1:0] edge_cnt
);

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         edge_detector_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .HOLDOFF     (HOLDOFF),
            .CNT_W       (CNT_W)
         ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .level_i    (level[i]),
            .mode_i     (mode[2*i +: 2]),
            .clr_i      (clr[i]),
            .p_edge_o   (p_edge[i]),
            .n_edge_o   (n_edge[i]),
            .evt_flag_o (evt_flag[i]),
            .edge_cnt_o (edge_cnt[CNT_W*i +: CNT_W])
         );
      end
   endgenerate

   // Both terms come straight from flops, so these stay glitch-free
   assign any_edge = p_edge | n_edge;
   assign irq      = |evt_flag;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed table, corner-case sequences and random
// stimulus checked against a sample-history reference model, on two parameter sets.

module tb_edge_detector_multi;

   localparam int CH_A = 8, S_A = 2, H_A = 4, W_A = 8;
   localparam int CH_B = 4, S_B = 1, H_B = 0, W_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [7:0]  level, clr;
   logic [15:0] mode;

   logic [7:0]  pa, na, aa, fa;
   logic        irqa;
   logic [63:0] ca;
   logic [3:0]  pb, nb, ab, fb;
   logic        irqb;
   logic [15:0] cb;

   edge_detector_multi #(.CH(CH_A), .SYNC_STAGES(S_A), .HOLDOFF(H_A), .CNT_W(W_A)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .clr(clr),
      .p_edge(pa), .n_edge(na), .any_edge(aa), .evt_flag(fa), .irq(irqa), .edge_cnt(ca));

   edge_detector_multi #(.CH(CH_B), .SYNC_STAGES(S_B), .HOLDOFF(H_B), .CNT_W(W_B)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .level(level[3:0]), .mode(mode[7:0]), .clr(clr[3:0]),
      .p_edge(pb), .n_edge(nb), .any_edge(ab), .evt_flag(fb), .irq(irqb), .edge_cnt(cb));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: mh[d][j] is the level seen j clock edges ago (zeroed by reset).
   // An edge is visible once it is S samples old; it is reported if enabled by mode and
   // at least H+1 cycles have passed since the last reported edge on that channel.
   int P_CH[2] = '{CH_A, CH_B};
   int P_S[2]  = '{S_A, S_B};
   int P_H[2]  = '{H_A, H_B};
   int P_W[2]  = '{W_A, W_B};

   bit [7:0] mh[2][0:4];
   int       m_last[2][8];
   int       m_cnt[2][8];
   bit       m_flag[2][8], m_p[2][8], m_n[2][8];
   int       m_cyc = 0;

   task automatic model_step(input int d);
      bit s, pv, rr, rf, rep;
      int mx;
      if (!reset_n) begin
         for (int j = 0; j < 5; j++) mh[d][j] = '0;
         for (int c = 0; c < 8; c++) begin
            m_p[d][c] = 0; m_n[d][c] = 0; m_flag[d][c] = 0;
            m_cnt[d][c] = 0; m_last[d][c] = -100;
         end
         return;
      end
      for (int j = 4; j > 0; j--) mh[d][j] = mh[d][j-1];
      mh[d][0] = level;
      mx = (1 << P_W[d]) - 1;
      for (int c = 0; c < P_CH[d]; c++) begin
         s  = mh[d][P_S[d]][c];
         pv = mh[d][P_S[d]+1][c];
         rr = s && !pv && mode[2*c]   && (m_cyc - m_last[d][c] > P_H[d]);
         rf = !s && pv && mode[2*c+1] && (m_cyc - m_last[d][c] > P_H[d]);
         rep = rr | rf;
         m_p[d][c] = rr;
         m_n[d][c] = rf;
         if (rep) m_last[d][c] = m_cyc;
         m_flag[d][c] = rep | (m_flag[d][c] & !clr[c]);
         if (clr[c])  m_cnt[d][c] = rep ? 1 : 0;
         else if (rep) m_cnt[d][c] = (m_cnt[d][c] + 1 > mx) ? mx : m_cnt[d][c] + 1;
      end
   endtask

   task automatic check_model();
      logic [7:0]  ep[2], en[2], ef[2];
      logic [63:0] ec[2];
      for (int d = 0; d < 2; d++) begin
         ep[d] = '0; en[d] = '0; ef[d] = '0; ec[d] = '0;
         for (int c = 0; c < P_CH[d]; c++) begin
            ep[d][c] = m_p[d][c];
            en[d][c] = m_n[d][c];
            ef[d][c] = m_flag[d][c];
            ec[d]    = ec[d] | (64'(m_cnt[d][c]) << (c * P_W[d]));
         end
      end
      chk("A p_edge",   pa,   ep[0]);
      chk("A n_edge",   na,   en[0]);
      chk("A any_edge", aa,   ep[0] | en[0]);
      chk("A evt_flag", fa,   ef[0]);
      chk("A irq",      irqa, |ef[0]);
      chk("A edge_cnt", ca,   ec[0]);
      chk("B p_edge",   pb,   ep[1][3:0]);
      chk("B n_edge",   nb,   en[1][3:0]);
      chk("B any_edge", ab,   ep[1][3:0] | en[1][3:0]);
      chk("B evt_flag", fb,   ef[1][3:0]);
      chk("B irq",      irqb, |ef[1]);
      chk("B edge_cnt", cb,   ec[1][15:0]);
   endtask

   // One clock: inputs already set; model advances at the edge, outputs checked at negedge
   task automatic step();
      @(posedge clk);
      m_cyc++;
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; level = '0; mode = '0; clr = '0;
      step();
      reset_n = 1'b1;
   endtask

   typedef struct {
      bit       l;
      bit [1:0] m;
      bit       c;
      bit       p;
      bit       n;
      bit       f;
      int       cnt;
   } vec_t;

   vec_t tbl[15];

   initial begin
      bit [7:0] seen_p, seen_n;
      int       rep_t[$];
      int       b_pulses, prev_cb, cb_drop;

      // channel 0 on DUT A: rise, fall, lone clear, clear coinciding with a reported edge
      tbl = '{'{1,3,0, 0,0,0,0}, '{1,3,0, 0,0,0,0}, '{1,3,0, 1,0,1,1}, '{1,3,0, 0,0,1,1},
              '{1,3,0, 0,0,1,1}, '{1,3,0, 0,0,1,1}, '{0,3,0, 0,0,1,1}, '{0,3,0, 0,0,1,1},
              '{0,3,0, 0,1,1,2}, '{0,3,0, 0,0,1,2}, '{0,3,1, 0,0,0,0}, '{1,3,0, 0,0,0,0},
              '{1,3,0, 0,0,0,0}, '{1,3,1, 1,0,1,1}, '{1,3,0, 0,0,1,1}};

      do_reset();
      chk("reset A outputs", {pa, na, fa, 7'b0, irqa}, 32'h0);
      chk("reset A edge_cnt", ca, 64'h0);

      for (int i = 0; i < 15; i++) begin
         level[0] = tbl[i].l; mode[1:0] = tbl[i].m; clr[0] = tbl[i].c;
         step();
         chk($sformatf("tbl[%0d] p_edge", i),   pa[0],    tbl[i].p);
         chk($sformatf("tbl[%0d] n_edge", i),   na[0],    tbl[i].n);
         chk($sformatf("tbl[%0d] evt_flag", i), fa[0],    tbl[i].f);
         chk($sformatf("tbl[%0d] irq", i),      irqa,     tbl[i].f);
         chk($sformatf("tbl[%0d] edge_cnt", i), ca[7:0],  64'(tbl[i].cnt));
      end
      clr = '0;

      // mode filtering: ch1 rising only, ch2 falling only, ch3 off
      do_reset();
      mode = 16'h0024; seen_p = '0; seen_n = '0;
      for (int i = 0; i < 18; i++) begin
         level[3:1] = (i < 8) ? 3'b111 : 3'b000;
         step();
         seen_p |= pa; seen_n |= na;
      end
      chk("mode p_edge ch1..3", seen_p[3:1], 3'b001);
      chk("mode n_edge ch1..3", seen_n[3:1], 3'b010);
      chk("mode ch1 cnt", ca[15:8],  1);
      chk("mode ch2 cnt", ca[23:16], 1);
      chk("mode ch3 cnt", ca[31:24], 0);
      chk("mode ch3 flag", fa[3], 0);

      // chatter: toggle every cycle; A reports every HOLDOFF+1, B (no holdoff) every toggle
      do_reset();
      mode = 16'h0003; b_pulses = 0;
      for (int t = 0; t < 20; t++) begin
         if (t < 12) level[0] = ~level[0];
         step();
         if (aa[0]) rep_t.push_back(t);
         if (ab[0]) b_pulses++;
      end
      chk("chatter A report count", rep_t.size(), 3);
      chk("chatter A cnt vs pulses", ca[7:0], rep_t.size());
      for (int i = 1; i < rep_t.size(); i++)
         chk($sformatf("chatter spacing %0d", i), rep_t[i] - rep_t[i-1], H_A + 1);
      chk("chatter B pulses", b_pulses, 12);
      chk("chatter B cnt", cb[3:0], 12);

      // saturation on B (4-bit counter): 12 more reported edges must stop at 15
      cb_drop = 0; prev_cb = cb[3:0];
      for (int t = 0; t < 14; t++) begin
         if (t < 12) level[0] = ~level[0];
         step();
         if (int'(cb[3:0]) < prev_cb) cb_drop = 1;
         prev_cb = cb[3:0];
      end
      chk("sat B cnt", cb[3:0], 15);
      chk("sat B no wrap", cb_drop, 0);

      // reset in the middle of a holdoff window with flags set
      do_reset();
      mode = 16'h0303; level = 8'h11;
      for (int i = 0; i < 4; i++) step();
      chk("pre-reset flags", fa & 8'h11, 8'h11);
      reset_n = 1'b0;
      step();
      chk("mid reset pulses", {pa, na}, 16'h0);
      chk("mid reset flags/irq", {fa, 7'b0, irqa}, 16'h0);
      chk("mid reset edge_cnt", ca, 64'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("release p_edge[4] t%0d", i), pa[4], (i == 2));
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         level = level ^ (8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 39) == 0) mode = 16'($urandom);
         clr = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h0;
         reset_n = ($urandom_range(0, 249) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Multi-channel, parametrised successor to the single-channel Mealy edge detector.
- Each channel provides:
  - an optional input synchroniser;
  - per-channel edge-mode selection (off / rising / falling / both);
  - a programmable holdoff window that ignores chatter after a reported edge;
  - registered edge pulses, a sticky event flag with clear, and a saturating edge counter.
- Sits between the debouncers / raw pin inputs and the control logic or interrupt path.

Parameters:
- CH, 8, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (0..3; 0 = bypass, input already synchronous).
- HOLDOFF, 4, cycles after a reported edge during which further edges on that channel are suppressed (0 = disabled).
- CNT_W, 8, width of each per-channel edge counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- level  input  CH  raw level inputs, bit i = channel i.
- mode  input  2*CH  bits [2i+1:2i] = channel i mode: 00 off, 01 rising, 10 falling, 11 both.
- clr  input  CH  per-channel clear of the sticky flag and counter.
- p_edge  output  CH  one-cycle pulse, reported rising edge.
- n_edge  output  CH  one-cycle pulse, reported falling edge.
- any_edge  output  CH  p_edge | n_edge.
- evt_flag  output  CH  sticky event flag per channel.
- irq  output  1  OR of all evt_flag bits.
- edge_cnt  output  CH*CNT_W  bits [CNT_W*(i+1)-1:CNT_W*i] = channel i saturating reported-edge count.

Behaviour:
- Reset (reset_n=0 at a clk rising edge):
  - Clears all synchroniser flops, prev registers, holdoff counters, p_edge, n_edge, evt_flag and edge_cnt.
  - irq=0.
  - Reset mid-operation aborts any holdoff window and discards in-flight pulses.
- Synchroniser: s_i = last stage of a SYNC_STAGES-deep shift of level[i]; with SYNC_STAGES=0, s_i = level[i].
- Previous-value register: prev_i <= s_i every cycle, regardless of mode or holdoff. A suppressed edge therefore never appears later.
- Raw edge detection: rise_i = s_i & ~prev_i; fall_i = ~s_i & prev_i.
- Qualification: rep_rise_i = rise_i & mode[2i] & (hold_i==0); rep_fall_i = fall_i & mode[2i+1] & (hold_i==0).
- Output registers (no combinational path from level to any output):
  - p_edge[i] <= rep_rise_i; n_edge[i] <= rep_fall_i.
  - any_edge is the OR of the two registers.
- Latency: a level change stable before clk edge k appears on p_edge/n_edge during the cycle after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 cycles.
- Pulse width: each reported edge gives exactly one cycle high.
- Holdoff, per channel:
  - A reported edge (rep_rise|rep_fall) loads hold_i = HOLDOFF.
  - Otherwise hold_i decrements toward 0 and stops at 0.
  - Edges with hold_i != 0 are suppressed; suppressed edges do not reload the counter.
  - Edges of a direction disabled by mode do not start holdoff.
  - The next edge can be reported at the earliest HOLDOFF+1 cycles after the previous one.
- Mode: sampled combinationally each cycle, so a change takes effect on the next compare. Mode 00 suppresses everything but prev still tracks.
- Sticky flag:
  - evt_flag[i] sets on a reported edge and clears on clr[i].
  - Set and clr in the same cycle: the flag ends set (set wins).
- Counter:
  - edge_cnt_i increments by 1 on each reported edge and saturates at 2^CNT_W-1 (no wrap).
  - clr[i] sets it to 0.
  - clr with a simultaneous reported edge loads 1.
- irq: combinational OR of the evt_flag registers (glitch-free, register-sourced).
- Reset release: prev and sync are 0, so a channel whose input is high at reset release reports one rising edge (if enabled) SYNC_STAGES+1 cycles later.
- Channels are fully independent; no cross-channel priority.

Test Plan:
- Basic rise/fall:
  - Setup: CH=8, SYNC_STAGES=2, HOLDOFF=4, mode[1:0]=11, level[0] 0→1 held 20 cycles, then 1→0.
  - Required: p_edge[0] high for exactly 1 cycle, 3 cycles after the input change; n_edge[0] likewise after the fall; edge_cnt ch0=2; evt_flag[0]=1; irq=1.
- Mode filtering:
  - Setup: ch1 mode=01, ch2 mode=10, ch3 mode=00; drive the same pulse on all three.
  - Required: ch1 gives only p_edge, ch2 only n_edge, ch3 nothing; ch3 edge_cnt=0 and evt_flag=0.
- Holdoff chatter:
  - Setup: ch0 mode=11; toggle level[0] every cycle for 12 cycles.
  - Required: reported edges are spaced exactly 5 cycles apart and edge_cnt matches the count of reported pulses. With HOLDOFF=0, every toggle is reported.
- Clear interaction:
  - Step 1: pulse clr[0] alone. Required: evt_flag[0]=0, edge_cnt=0, irq=0 (other flags clear).
  - Step 2: assert clr[0] in the same cycle as a reported edge. Required: evt_flag[0]=1, edge_cnt=1.
- Saturation:
  - Setup: CNT_W=4; generate 20 reported edges on ch0.
  - Required: edge_cnt ch0 stops at 15 and does not wrap.
- Reset:
  - Step 1: assert reset_n=0 during a holdoff window with flags set. Required: next cycle all outputs are 0.
  - Step 2: hold level[4]=1 across reset release (mode 11). Required: one p_edge[4] 3 cycles after release.
